// File: rtl/write_back_stage.sv
// Write-back stage: selects the value to retire, extends sub-word loads and
// queues register-file writes in a small FIFO so that RF stalls never drop
// retired instructions. Writes to r0 or with the enable low are retired
// without producing an entry.
module write_back_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int DEPTH          = 2,
   localparam int OW = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH/8) : 1,
   localparam int CW = $clog2(DEPTH+1)
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      inValid,
   output logic                      inReady,
   input  logic [1:0]                writeBackControl,
   input  logic [1:0]                loadSize,
   input  logic                      loadSigned,
   input  logic [OW-1:0]             byteOffset,
   input  logic [DATA_WIDTH-1:0]     readData,
   input  logic [DATA_WIDTH-1:0]     result,
   input  logic [DATA_WIDTH-1:0]     linkAddress,
   input  logic [DATA_WIDTH-1:0]     immediate,
   input  logic [REG_ADDR_WIDTH-1:0] destReg,
   input  logic                      regWriteEnable,
   input  logic                      rfReady,
   output logic                      rfWrite,
   output logic [REG_ADDR_WIDTH-1:0] rfAddr,
   output logic [DATA_WIDTH-1:0]     writeData,
   output logic [CW-1:0]             pendingCount
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [CW-1:0]             r_count;
   logic [PW-1:0]             r_wrPtr;
   logic [PW-1:0]             r_rdPtr;
   logic [REG_ADDR_WIDTH-1:0] r_addrMem [DEPTH];
   logic [DATA_WIDTH-1:0]     r_dataMem [DEPTH];
   logic [REG_ADDR_WIDTH-1:0] r_outAddr;
   logic [DATA_WIDTH-1:0]     r_outData;

   logic                      w_push;
   logic                      w_pop;
   logic [PW-1:0]             w_nextRd;
   logic [7:0]                w_byte;
   logic [15:0]               w_half;
   logic [OW-1:0]             w_halfIdx;
   logic [DATA_WIDTH-1:0]     w_load;
   logic [DATA_WIDTH-1:0]     w_value;

   // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // inReady depends only on internal state, never on inValid/rfReady.
   assign inReady      = (r_count < CW'(DEPTH));
   assign rfWrite      = (r_count != '0);
   assign rfAddr       = r_outAddr;
   assign writeData    = r_outData;
   assign pendingCount = r_count;

   assign w_push   = inValid && inReady && regWriteEnable && (destReg != '0);
   assign w_pop    = rfWrite && rfReady;
   assign w_nextRd = f_inc(r_rdPtr);

   // Load lane extraction and sign/zero extension.
   always_comb begin
      w_halfIdx = byteOffset >> 1;
      w_byte    = readData[8*byteOffset +: 8];
      w_half    = readData[16*w_halfIdx +: 16];
      case (loadSize)
         2'd0:    w_load = {{(DATA_WIDTH-8){loadSigned & w_byte[7]}}, w_byte};
         2'd1:    w_load = {{(DATA_WIDTH-16){loadSigned & w_half[15]}}, w_half};
         default: w_load = readData;
      endcase
   end

   // Result select; an unknown control falls to a known value so it can
   // never propagate into pointers or other queued entries.
   always_comb begin
      w_value = '0;
      case (writeBackControl)
         2'd0:    w_value = result;
         2'd1:    w_value = w_load;
         2'd2:    w_value = linkAddress;
         2'd3:    w_value = immediate;
         default: w_value = '0;
      endcase
   end

   // Queue storage: contents are don't-care until pushed, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addrMem[r_wrPtr] <= destReg;
         r_dataMem[r_wrPtr] <= w_value;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= f_inc(r_wrPtr);
         if (w_pop)  r_rdPtr <= w_nextRd;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered head view: loads the entry that will be at the head after
   // this edge, or holds the last value when the queue drains.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_outAddr <= '0;
         r_outData <= '0;
      end else if (w_pop && (r_count > CW'(1))) begin
         r_outAddr <= r_addrMem[w_nextRd];
         r_outData <= r_dataMem[w_nextRd];
      end else if (w_push && ((r_count == '0) || (w_pop && (r_count == CW'(1))))) begin
         r_outAddr <= destReg;
         r_outData <= w_value;
      end
   end

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage (DATA_WIDTH=32, DEPTH=2).
module tb_write_back_stage;

   logic        clk = 1'b0;
   logic        resetN;
   logic        inValid;
   logic        inReady;
   logic [1:0]  writeBackControl;
   logic [1:0]  loadSize;
   logic        loadSigned;
   logic [1:0]  byteOffset;
   logic [31:0] readData;
   logic [31:0] result;
   logic [31:0] linkAddress;
   logic [31:0] immediate;
   logic [4:0]  destReg;
   logic        regWriteEnable;
   logic        rfReady;
   logic        rfWrite;
   logic [4:0]  rfAddr;
   logic [31:0] writeData;
   logic [1:0]  pendingCount;

   int errors = 0;
   int checks = 0;

   write_back_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .DEPTH(2)) dut (
      .clk(clk), .resetN(resetN), .inValid(inValid), .inReady(inReady),
      .writeBackControl(writeBackControl), .loadSize(loadSize),
      .loadSigned(loadSigned), .byteOffset(byteOffset), .readData(readData),
      .result(result), .linkAddress(linkAddress), .immediate(immediate),
      .destReg(destReg), .regWriteEnable(regWriteEnable), .rfReady(rfReady),
      .rfWrite(rfWrite), .rfAddr(rfAddr), .writeData(writeData),
      .pendingCount(pendingCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic head(input string tag, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [1:0] c);
      chk({tag, ".rfWrite"}, {31'd0, rfWrite}, {31'd0, w});
      chk({tag, ".rfAddr"}, {27'd0, rfAddr}, {27'd0, a});
      chk({tag, ".data"}, writeData, d);
      chk({tag, ".count"}, {30'd0, pendingCount}, {30'd0, c});
   endtask

   task automatic drive(input logic [1:0] ctl, input logic [1:0] sz, input logic sg,
                        input logic [1:0] off, input logic [4:0] rd, input logic [31:0] res);
      inValid = 1'b1; writeBackControl = ctl; loadSize = sz; loadSigned = sg;
      byteOffset = off; destReg = rd; regWriteEnable = 1'b1; result = res;
   endtask

   initial begin
      resetN = 1'b0; inValid = 1'b0; writeBackControl = 2'd0; loadSize = 2'd0;
      loadSigned = 1'b0; byteOffset = 2'd0; readData = 32'h80F4_7F81;
      result = 32'd0; linkAddress = 32'd100; immediate = 32'h0000_1234;
      destReg = 5'd0; regWriteEnable = 1'b0; rfReady = 1'b1;
      step(); step();
      head("reset", 1'b0, 5'd0, 32'd0, 2'd0);
      chk("reset.inReady", {31'd0, inReady}, 32'd1);
      resetN = 1'b1;
      step();

      // Mux/extend; each edge pops the previous head and pushes the next.
      drive(2'd1, 2'd0, 1'b1, 2'd0, 5'd3, 32'd0);   step();
      head("byte_s_off0", 1'b1, 5'd3, 32'hFFFF_FF81, 2'd1);
      drive(2'd1, 2'd0, 1'b0, 2'd1, 5'd4, 32'd0);   step();
      head("byte_u_off1", 1'b1, 5'd4, 32'h0000_007F, 2'd1);
      drive(2'd1, 2'd1, 1'b1, 2'd2, 5'd5, 32'd0);   step();
      head("half_s_off2", 1'b1, 5'd5, 32'hFFFF_80F4, 2'd1);
      drive(2'd1, 2'd1, 1'b0, 2'd0, 5'd6, 32'd0);   step();
      head("half_u_off0", 1'b1, 5'd6, 32'h0000_7F81, 2'd1);
      drive(2'd0, 2'd0, 1'b0, 2'd0, 5'd7, 32'd200); step();
      head("ctl_result", 1'b1, 5'd7, 32'd200, 2'd1);
      drive(2'd2, 2'd0, 1'b0, 2'd0, 5'd8, 32'd0);   step();
      head("ctl_link", 1'b1, 5'd8, 32'd100, 2'd1);
      drive(2'd3, 2'd0, 1'b0, 2'd0, 5'd9, 32'd0);   step();
      head("ctl_imm", 1'b1, 5'd9, 32'h0000_1234, 2'd1);
      drive(2'd1, 2'd2, 1'b1, 2'd3, 5'd10, 32'd0);  step();
      head("full_word", 1'b1, 5'd10, 32'h80F4_7F81, 2'd1);
      inValid = 1'b0; step();
      head("drain_hold", 1'b0, 5'd10, 32'h80F4_7F81, 2'd0);

      // Suppressed writes: accepted but never queued.
      drive(2'd0, 2'd0, 1'b0, 2'd0, 5'd0, 32'd55); step();
      head("r0_suppr", 1'b0, 5'd10, 32'h80F4_7F81, 2'd0);
      chk("r0_suppr.inReady", {31'd0, inReady}, 32'd1);
      drive(2'd0, 2'd0, 1'b0, 2'd0, 5'd5, 32'd66); regWriteEnable = 1'b0; step();
      head("we_suppr", 1'b0, 5'd10, 32'h80F4_7F81, 2'd0);
      chk("we_suppr.inReady", {31'd0, inReady}, 32'd1);

      // Back-pressure with DEPTH=2.
      rfReady = 1'b0;
      drive(2'd0, 2'd0, 1'b0, 2'd0, 5'd1, 32'd10); step();
      head("bp_push1", 1'b1, 5'd1, 32'd10, 2'd1);
      chk("bp_push1.inReady", {31'd0, inReady}, 32'd1);
      drive(2'd0, 2'd0, 1'b0, 2'd0, 5'd2, 32'd20); step();
      head("bp_full", 1'b1, 5'd1, 32'd10, 2'd2);
      chk("bp_full.inReady", {31'd0, inReady}, 32'd0);
      drive(2'd0, 2'd0, 1'b0, 2'd0, 5'd3, 32'd30); step();
      head("bp_held", 1'b1, 5'd1, 32'd10, 2'd2);
      rfReady = 1'b1; step();
      head("bp_pop1", 1'b1, 5'd2, 32'd20, 2'd1);
      chk("bp_pop1.inReady", {31'd0, inReady}, 32'd1);
      step();
      head("bp_pop2_push3", 1'b1, 5'd3, 32'd30, 2'd1);
      inValid = 1'b0; step();
      head("bp_empty", 1'b0, 5'd3, 32'd30, 2'd0);

      // Streaming: 8 back-to-back writes, pointers wrap several times.
      for (int i = 0; i < 8; i++) begin
         drive(2'd0, 2'd0, 1'b0, 2'd0, 5'(11 + i), 32'(1000 + i)); step();
         head($sformatf("stream%0d", i), 1'b1, 5'(11 + i), 32'(1000 + i), 2'd1);
      end
      inValid = 1'b0; step();
      head("stream_end", 1'b0, 5'd18, 32'd1007, 2'd0);

      // Unknown control must not disturb the queue or pointers.
      rfReady = 1'b0;
      drive(2'd0, 2'd0, 1'b0, 2'd0, 5'd20, 32'd77); step();
      drive(2'bxx, 2'd0, 1'b0, 2'd0, 5'd21, 32'd0); step();
      inValid = 1'b0;
      head("xctl_full", 1'b1, 5'd20, 32'd77, 2'd2);
      rfReady = 1'b1; step();
      chk("xctl_addr", {27'd0, rfAddr}, 32'd21);
      chk("xctl_count", {30'd0, pendingCount}, 32'd1);
      step();
      chk("xctl_drain", {30'd0, pendingCount}, 32'd0);

      // Asynchronous reset during a stall drops pending writes at once.
      rfReady = 1'b0;
      drive(2'd0, 2'd0, 1'b0, 2'd0, 5'd22, 32'd88); step();
      drive(2'd0, 2'd0, 1'b0, 2'd0, 5'd23, 32'd99); step();
      inValid = 1'b0;
      chk("pre_rst_count", {30'd0, pendingCount}, 32'd2);
      #2 resetN = 1'b0;
      #1;
      head("async_rst", 1'b0, 5'd0, 32'd0, 2'd0);
      chk("async_rst.inReady", {31'd0, inReady}, 32'd1);
      resetN = 1'b1; rfReady = 1'b1;
      step();
      head("post_rst", 1'b0, 5'd0, 32'd0, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
